// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioning front end.
package btn_pkg;

  typedef enum logic [1:0] {
    LOW  = 2'b00,
    RISE = 2'b01,
    HIGH = 2'b10,
    FALL = 2'b11
  } btn_state_t;

  localparam int DEBOUNCE_DEFAULT = 1000000;
  localparam int HOLD_DEFAULT     = 100000000;

  // Smallest width able to hold values 0 .. value-1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((64'(1) << result) < 64'(value)) result++;
    return result;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer, debounce/hold FSM sharing one counter,
// and registered level plus press/release/hold pulses.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int HOLD_CYCLES     = HOLD_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel,
  output logic hold
);

  localparam int CNT_W = clog2(max_int(DEBOUNCE_CYCLES, HOLD_CYCLES) + 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam bit               DEB_ONE   = (DEBOUNCE_CYCLES == 1);

  logic             s1, s2;
  btn_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             hold_done, hold_done_nxt;
  logic             level_nxt, press_nxt, rel_nxt, hold_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      state     <= LOW;
      cnt       <= '0;
      hold_done <= 1'b0;
      level     <= 1'b0;
      press     <= 1'b0;
      rel       <= 1'b0;
      hold      <= 1'b0;
    end else begin
      s1        <= raw;
      s2        <= s1;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      hold_done <= hold_done_nxt;
      level     <= level_nxt;
      press     <= press_nxt;
      rel       <= rel_nxt;
      hold      <= hold_nxt;
    end
  end

  // The sample that leaves LOW/HIGH is the first agreeing sample, so the
  // pending state starts counting at 1.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    hold_done_nxt = hold_done;
    level_nxt     = level;
    press_nxt     = 1'b0;
    rel_nxt       = 1'b0;
    hold_nxt      = 1'b0;
    unique case (state)
      LOW: begin
        cnt_nxt       = '0;
        hold_done_nxt = 1'b0;
        if (s2) begin
          if (DEB_ONE) begin
            state_nxt = HIGH;
            level_nxt = 1'b1;
            press_nxt = 1'b1;
          end else begin
            state_nxt = RISE;
            cnt_nxt   = CNT_ONE;
          end
        end
      end
      RISE: begin
        if (!s2) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = HIGH;
          level_nxt = 1'b1;
          press_nxt = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      HIGH: begin
        if (!s2) begin
          if (DEB_ONE) begin
            state_nxt     = LOW;
            level_nxt     = 1'b0;
            rel_nxt       = 1'b1;
            cnt_nxt       = '0;
            hold_done_nxt = 1'b0;
          end else begin
            state_nxt = FALL;
            cnt_nxt   = CNT_ONE;
          end
        end else if (cnt == HOLD_LAST) begin
          // Counter saturates here; hold_done keeps the pulse to one per press.
          if (!hold_done) begin
            hold_nxt      = 1'b1;
            hold_done_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      FALL: begin
        if (s2) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt     = LOW;
          level_nxt     = 1'b0;
          rel_nxt       = 1'b1;
          cnt_nxt       = '0;
          hold_done_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/button_conditioner.sv
// Conditions N_BTN raw asynchronous buttons into debounced levels and
// one-cycle press/release/hold pulses, one independent channel per bit.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int HOLD_CYCLES     = HOLD_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_hold
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .reset(reset),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .press(btn_press[i]),
      .rel  (btn_release[i]),
      .hold (btn_hold[i])
    );
  end

endmodule
